// File: rtl/credit_menu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : credit_menu_pkg
//  Description : Shared definitions for the credit-menu renderer. Contains
//                the fade FSM state encoding, fade level range and the
//                3-3-2 colour field layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package credit_menu_pkg;

    // Fade state machine encoding (2-bit)
    typedef enum logic [1:0] {
        ST_HIDDEN   = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOWN    = 2'd2,
        ST_FADE_OUT = 2'd3
    } menu_state_t;

    // Fade level runs 0..LEVEL_MAX. LEVEL_MAX is a power of two, so scaling
    // by level/LEVEL_MAX becomes a multiply followed by a right shift.
    localparam int LEVEL_MAX   = 8;
    localparam int LEVEL_W     = 4;
    localparam int LEVEL_SHIFT = 3;

    // 3-3-2 colour layout: R[7:5], G[4:2], B[1:0]
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;
    localparam int R_W   = R_MSB - R_LSB + 1;
    localparam int G_W   = G_MSB - G_LSB + 1;
    localparam int B_W   = B_MSB - B_LSB + 1;

endpackage
`default_nettype wire

// File: rtl/credit_menu_renderer_color_scale_332.sv
`default_nettype none
// ============================================================================
//  Module      : color_scale_332
//  Description : Purely combinational brightness scaler for a 3-3-2 pixel.
//                Each channel becomes (channel * level) >> 3, so level 8
//                passes the colour through and level 0 gives black.
//  Ports       : color  - input 3-3-2 colour
//                level  - fade level 0..8
//                scaled - scaled 3-3-2 colour
//  Revision    : 1.0 - initial release
// ============================================================================
module color_scale_332
    import credit_menu_pkg::*;
(
    input  logic [7:0]         color,
    input  logic [LEVEL_W-1:0] level,
    output logic [7:0]         scaled
);

    // Product widths: channel bits + level bits, wide enough for 7*8 or 3*8.
    localparam int R_PW = R_W + LEVEL_W;
    localparam int G_PW = G_W + LEVEL_W;
    localparam int B_PW = B_W + LEVEL_W;

    // With level <= LEVEL_MAX the shifted product always fits the channel.
    assign scaled[R_MSB:R_LSB] =
        R_W'((R_PW'(color[R_MSB:R_LSB]) * R_PW'(level)) >> LEVEL_SHIFT);
    assign scaled[G_MSB:G_LSB] =
        G_W'((G_PW'(color[G_MSB:G_LSB]) * G_PW'(level)) >> LEVEL_SHIFT);
    assign scaled[B_MSB:B_LSB] =
        B_W'((B_PW'(color[B_MSB:B_LSB]) * B_PW'(level)) >> LEVEL_SHIFT);

endmodule
`default_nettype wire

// File: rtl/credit_menu_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : credit_menu_renderer
//  Description : Consumer side of the credit-menu image ROM. Converts the VGA
//                scan position into ROM row/col addresses, aligns the window
//                flags with the ROM's one-cycle read latency, and produces a
//                registered 3-3-2 pixel faded by a frame-synchronous
//                HIDDEN/FADE_IN/SHOWN/FADE_OUT state machine.
//  Ports       : clk, reset              - pixel clock, sync active-high reset
//                video_on, pixel_x/y     - scan position from sync generator
//                frame_tick              - one pulse per frame (vblank start)
//                show_req, hide_req      - one-cycle menu requests
//                rom_row, rom_col        - combinational ROM address
//                rom_data                - ROM colour, one cycle after address
//                rgb_out                 - registered pixel colour
//                menu_visible, fade_busy - status
//  Options     : CREDIT_MENU_BLINK_EN - blink the sprite while SHOWN, toggling
//                every BLINK_FRAMES frame ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_menu_renderer
    import credit_menu_pkg::*;
#(
    parameter logic [9:0] ORIGIN_X        = 10'd256,
    parameter logic [9:0] ORIGIN_Y        = 10'd200,
    parameter logic [9:0] SPRITE_W        = 10'd128,
    parameter logic [9:0] SPRITE_H        = 10'd32,
    parameter int         FRAMES_PER_STEP = 4,
    parameter logic [7:0] BG_COLOR        = 8'h00,
    parameter int         BLINK_FRAMES    = 32
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic       show_req,
    input  logic       hide_req,
    output logic [9:0] rom_row,
    output logic [9:0] rom_col,
    input  logic [7:0] rom_data,
    output logic [7:0] rgb_out,
    output logic       menu_visible,
    output logic       fade_busy
);

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);

    if (FRAMES_PER_STEP < 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("credit_menu_renderer: FRAMES_PER_STEP and BLINK_FRAMES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Window test and ROM addressing. Unsigned 10-bit subtraction: a scan
    // position left of / above the origin wraps to a large value and so
    // fails the size compare without a separate lower-bound check.
    // ------------------------------------------------------------------
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_win;

    assign w_dx     = pixel_x - ORIGIN_X;
    assign w_dy     = pixel_y - ORIGIN_Y;
    assign w_in_win = video_on & (w_dx < SPRITE_W) & (w_dy < SPRITE_H);
    assign rom_row  = w_in_win ? w_dy : 10'd0;
    assign rom_col  = w_in_win ? w_dx : 10'd0;

    // ------------------------------------------------------------------
    // Fade state machine
    // ------------------------------------------------------------------
    menu_state_t        r_state;
    menu_state_t        w_state_nxt;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [STEP_W-1:0]  w_step_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_HIDDEN;
            r_level    <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_step_cnt <= w_step_nxt;
        end
    end

    // Request handling has priority over frame stepping, so a frame_tick in
    // the same cycle as a direction change is absorbed by the transition.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_step_nxt  = r_step_cnt;
        case (r_state)
            ST_HIDDEN: begin
                if (show_req && !hide_req) begin
                    w_state_nxt = ST_FADE_IN;
                    w_step_nxt  = '0;
                end
            end
            ST_FADE_IN: begin
                if (hide_req) begin
                    w_state_nxt = ST_FADE_OUT;
                    w_step_nxt  = '0;
                end else if (frame_tick) begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_nxt = '0;
                        // Saturating: a reversal from FADE_OUT at full
                        // level must not overshoot LEVEL_MAX.
                        if (r_level >= LVL_MAX - LEVEL_W'(1)) begin
                            w_level_nxt = LVL_MAX;
                            w_state_nxt = ST_SHOWN;
                        end else begin
                            w_level_nxt = r_level + LEVEL_W'(1);
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + STEP_W'(1);
                    end
                end
            end
            ST_SHOWN: begin
                if (hide_req) begin
                    w_state_nxt = ST_FADE_OUT;
                    w_step_nxt  = '0;
                end
            end
            ST_FADE_OUT: begin
                if (show_req && !hide_req) begin
                    w_state_nxt = ST_FADE_IN;
                    w_step_nxt  = '0;
                end else if (frame_tick) begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_nxt = '0;
                        // Saturating: a reversal from FADE_IN at level 0
                        // must not underflow.
                        if (r_level <= LEVEL_W'(1)) begin
                            w_level_nxt = '0;
                            w_state_nxt = ST_HIDDEN;
                        end else begin
                            w_level_nxt = r_level - LEVEL_W'(1);
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + STEP_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HIDDEN;
                w_level_nxt = '0;
                w_step_nxt  = '0;
            end
        endcase
    end

    assign menu_visible = (r_state != ST_HIDDEN);
    assign fade_busy    = (r_state == ST_FADE_IN) || (r_state == ST_FADE_OUT);

    // ------------------------------------------------------------------
    // Optional blink while SHOWN
    // ------------------------------------------------------------------
    logic w_blank;

`ifdef CREDIT_MENU_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blank;

    // Cleared on the edge that leaves SHOWN, so a hide_req stops blinking
    // from the very next cycle.
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_SHOWN || w_state_nxt != ST_SHOWN) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign w_blank = r_blank;
`else
    assign w_blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pixel pipeline: d1 flags line up with rom_data, rgb_out one later.
    // ------------------------------------------------------------------
    logic       r_in_win_d1;
    logic       r_video_d1;
    logic [7:0] w_scaled;

    color_scale_332 u_scale (
        .color  (rom_data),
        .level  (r_level),
        .scaled (w_scaled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_win_d1 <= 1'b0;
            r_video_d1  <= 1'b0;
            rgb_out     <= 8'h00;
        end else begin
            r_in_win_d1 <= w_in_win;
            r_video_d1  <= video_on;
            if (!r_video_d1) begin
                rgb_out <= 8'h00;
            end else if (!r_in_win_d1 || rom_data == 8'h00 ||
                         r_level == '0 || w_blank) begin
                rgb_out <= BG_COLOR;
            end else begin
                rgb_out <= w_scaled;
            end
        end
    end

endmodule
`default_nettype wire
